// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared constants and types for the multiply unit
//
// Purpose: operation codes seen on the op/mul stall interface, the FSM state
// encoding of the sequential multiplier, and the default operand width.
// Ports: none (package).

package mul_pkg;

  // Operation codes carried on op (request) and mul (in-flight / stall code)
  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_MULT  = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  // Default operand width; HI and LO are each this wide
  localparam int MUL_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10
  } mul_state_t;

endpackage

// File: rtl/mul_step.sv
// rtl/mul_step.sv - one combinational add-and-shift iteration
//
// Purpose: given the partial product register and the multiplicand, form the
// partial product after one shift-add step. The upper half gets the
// multiplicand added when the current multiplier bit (prod[0]) is set; the sum
// is kept WIDTH+1 bits wide so its carry shifts into the top bit.
// Ports:
//   prod       in   2*WIDTH  current partial product {upper, remaining multiplier}
//   mcand      in   WIDTH    multiplicand (unsigned)
//   prod_next  out  2*WIDTH  partial product after this iteration

module mul_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] prod,
  input  logic [WIDTH-1:0]   mcand,
  output logic [2*WIDTH-1:0] prod_next
);

  logic [WIDTH:0] addend;
  logic [WIDTH:0] sum;

  always_comb begin
    addend    = prod[0] ? {1'b0, mcand} : '0;
    sum       = {1'b0, prod[2*WIDTH-1:WIDTH]} + addend;
    // Carry lands in the top bit; the consumed multiplier bit falls off the bottom
    prod_next = {sum, prod[WIDTH-1:1]};
  end

endmodule

// File: rtl/seq_mul_unit.sv
// rtl/seq_mul_unit.sv - multi-cycle shift-add MULT/MULTU unit owning HI/LO
//
// Purpose: accepts a MULT or MULTU request in IDLE, forms the product one bit
// per cycle over WIDTH cycles (RUN), applies the sign in a single FIX cycle and
// writes HI/LO. While an operation is in flight, mul carries its op code so the
// pipeline can stall on mul != 0.
// Ports:
//   clk    in   1      clock, rising edge
//   rst    in   1      asynchronous active-low reset
//   start  in   1      request, sampled only in IDLE
//   op     in   2      00 none, 01 MULTU, 10 MULT, 11 reserved
//   a_in   in   WIDTH  multiplicand (rs)
//   b_in   in   WIDTH  multiplier (rt)
//   flush  in   1      synchronous abort of an in-flight operation
//   mul    out  2      op code in flight, 00 when idle
//   busy   out  1      high in RUN and FIX
//   done   out  1      one-cycle pulse in the cycle HI/LO first show a new result
//   hi     out  WIDTH  upper product half
//   lo     out  WIDTH  lower product half

module seq_mul_unit
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH_DEF,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             flush,
  output logic [1:0]       mul,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  mul_state_t           state, state_next;
  logic [2*WIDTH-1:0]   prod;
  logic [2*WIDTH-1:0]   prod_next;
  logic [2*WIDTH-1:0]   result;
  logic [WIDTH-1:0]     mcand;
  logic [CNT_W-1:0]     cnt;
  logic                 neg;
  logic                 accept;
  logic [WIDTH-1:0]     a_abs;
  logic [WIDTH-1:0]     b_abs;

  mul_step #(.WIDTH(WIDTH)) u_step (
    .prod      (prod),
    .mcand     (mcand),
    .prod_next (prod_next)
  );

  // Magnitudes for MULT. The most-negative value negates to itself, which read
  // as unsigned is exactly its magnitude, so no special case is needed.
  always_comb begin
    a_abs  = a_in[WIDTH-1] ? (-a_in) : a_in;
    b_abs  = b_in[WIDTH-1] ? (-b_in) : b_in;
    result = neg ? (-prod) : prod;
    accept = (state == S_IDLE) && start && ((op == OP_MULTU) || (op == OP_MULT));
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept) state_next = S_RUN;
      end
      S_RUN: begin
        if (flush)                 state_next = S_IDLE;
        else if (cnt == LAST_CNT)  state_next = S_FIX;
      end
      S_FIX: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mul   <= OP_NONE;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      prod  <= '0;
      mcand <= '0;
      neg   <= 1'b0;
      cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            mul <= op;
            cnt <= '0;
            if (op == OP_MULT) begin
              mcand <= a_abs;
              prod  <= {{WIDTH{1'b0}}, b_abs};
              neg   <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
            end else begin
              mcand <= a_in;
              prod  <= {{WIDTH{1'b0}}, b_in};
              neg   <= 1'b0;
            end
          end
        end
        S_RUN: begin
          if (flush) begin
            mul <= OP_NONE;
          end else begin
            prod <= prod_next;
            cnt  <= cnt + CNT_W'(1);
          end
        end
        S_FIX: begin
          mul <= OP_NONE;
          // An abort in the last cycle still wins: HI/LO keep the old product
          if (!flush) begin
            hi   <= result[2*WIDTH-1:WIDTH];
            lo   <= result[WIDTH-1:0];
            done <= 1'b1;
          end
        end
        default: begin
          mul <= OP_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mul_unit.sv
// tb/tb_seq_mul_unit.sv - directed self-checking bench for seq_mul_unit

module tb_seq_mul_unit;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             flush;
  logic [1:0]       mul;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  int n_checks;
  int n_fail;

  seq_mul_unit #(.WIDTH(WIDTH), .CNT_W(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a_in  (a_in),
    .b_in  (b_in),
    .flush (flush),
    .mul   (mul),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a request for exactly one rising edge; returns at the negedge after it
  task automatic issue(input logic [1:0] o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a_in  = a;
    b_in  = b;
    @(negedge clk);
    start = 1'b0;
    op    = 2'b00;
  endtask

  // Advance negedges until done is seen or the budget runs out
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; op = 2'b00; a_in = '0; b_in = '0; flush = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({mul, busy, done, hi, lo} !== {2'b00, 1'b0, 1'b0, 32'h0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_state: mul=%b busy=%b done=%b hi=%h lo=%h, required all zero", mul, busy, done, hi, lo);
    end
    rst = 1'b1;
    // Reserved and none op codes must not start anything
    issue(2'b11, 32'd4, 32'd4);
    n_checks++;
    if (busy !== 1'b0 || mul !== 2'b00) begin
      n_fail++;
      $display("FAIL rsvd_op_ignored: busy=%b mul=%b, required 0/00", busy, mul);
    end
    issue(2'b00, 32'd4, 32'd4);
    n_checks++;
    if (busy !== 1'b0 || mul !== 2'b00) begin
      n_fail++;
      $display("FAIL none_op_ignored: busy=%b mul=%b, required 0/00", busy, mul);
    end
  endtask

  task automatic test_multu_basic();
    int bad;
    bad = 0;
    issue(2'b01, 32'd3, 32'd5);
    // Now in the first RUN cycle; expect 33 stall cycles with no done
    for (int i = 0; i < 33; i++) begin
      if (busy !== 1'b1 || mul !== 2'b01 || done !== 1'b0) bad++;
      @(negedge clk);
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL multu_busy_window: %0d bad cycles, required 0", bad);
    end
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || mul !== 2'b00) begin
      n_fail++;
      $display("FAIL multu_done_timing: done=%b busy=%b mul=%b, required 1/0/00", done, busy, mul);
    end
    n_checks++;
    if (hi !== 32'h0 || lo !== 32'h0000000F) begin
      n_fail++;
      $display("FAIL multu_3x5: hi=%h lo=%h, required 00000000/0000000f", hi, lo);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_single_pulse: done=%b, required 0", done);
    end
  endtask

  task automatic test_mult_signed_back_to_back();
    int cyc;
    issue(2'b10, 32'hFFFFFFFE, 32'h00000003);
    wait_done(cyc);
    n_checks++;
    if (done !== 1'b1 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin
      n_fail++;
      $display("FAIL mult_neg2x3: done=%b hi=%h lo=%h, required 1/ffffffff/fffffffa", done, hi, lo);
    end
    // First IDLE cycle: a new request must be taken at the very next edge
    start = 1'b1; op = 2'b10; a_in = 32'h80000000; b_in = 32'h80000000;
    @(negedge clk);
    start = 1'b0; op = 2'b00;
    n_checks++;
    if (busy !== 1'b1 || mul !== 2'b10) begin
      n_fail++;
      $display("FAIL back_to_back_accept: busy=%b mul=%b, required 1/10", busy, mul);
    end
    wait_done(cyc);
    n_checks++;
    if (done !== 1'b1 || hi !== 32'h40000000 || lo !== 32'h0) begin
      n_fail++;
      $display("FAIL mult_minxmin: done=%b hi=%h lo=%h, required 1/40000000/00000000", done, hi, lo);
    end
  endtask

  task automatic test_multu_max();
    int cyc;
    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(cyc);
    n_checks++;
    if (done !== 1'b1 || hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
      n_fail++;
      $display("FAIL multu_max: done=%b hi=%h lo=%h, required 1/fffffffe/00000001", done, hi, lo);
    end
  endtask

  task automatic test_start_while_busy();
    int dones;
    dones = 0;
    issue(2'b01, 32'd2, 32'd9);
    repeat (4) @(negedge clk);
    start = 1'b1; op = 2'b10; a_in = 32'hFFFFFFFF; b_in = 32'd2;
    @(negedge clk);
    start = 1'b0; op = 2'b00;
    n_checks++;
    if (mul !== 2'b01) begin
      n_fail++;
      $display("FAIL busy_start_mul: mul=%b, required 01", mul);
    end
    for (int i = 0; i < 60; i++) begin
      if (done === 1'b1) dones++;
      @(negedge clk);
    end
    n_checks++;
    if (dones != 1) begin
      n_fail++;
      $display("FAIL busy_start_done_count: %0d, required 1", dones);
    end
    n_checks++;
    if (hi !== 32'h0 || lo !== 32'h00000012 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_start_result: hi=%h lo=%h busy=%b, required 0/00000012/0", hi, lo, busy);
    end
  endtask

  task automatic test_flush();
    int cyc;
    int dones;
    dones = 0;
    issue(2'b01, 32'd3, 32'd5);
    wait_done(cyc);
    issue(2'b01, 32'h1234, 32'h10);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || mul !== 2'b00 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_idle: busy=%b mul=%b done=%b, required 0/00/0", busy, mul, done);
    end
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) dones++;
      @(negedge clk);
    end
    n_checks++;
    if (dones != 0 || hi !== 32'h0 || lo !== 32'h0000000F) begin
      n_fail++;
      $display("FAIL flush_keep: dones=%0d hi=%h lo=%h, required 0/00000000/0000000f", dones, hi, lo);
    end
    // Flush while idle changes nothing
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || lo !== 32'h0000000F) begin
      n_fail++;
      $display("FAIL flush_in_idle: busy=%b lo=%h, required 0/0000000f", busy, lo);
    end
  endtask

  task automatic test_async_reset();
    int cyc;
    issue(2'b01, 32'd5, 32'd5);
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({mul, busy, done, hi, lo} !== {2'b00, 1'b0, 1'b0, 32'h0, 32'h0}) begin
      n_fail++;
      $display("FAIL async_reset_clear: mul=%b busy=%b done=%b hi=%h lo=%h, required all zero", mul, busy, done, hi, lo);
    end
    @(negedge clk);
    rst = 1'b1;
    issue(2'b01, 32'd7, 32'd6);
    wait_done(cyc);
    n_checks++;
    if (done !== 1'b1 || hi !== 32'h0 || lo !== 32'h0000002A) begin
      n_fail++;
      $display("FAIL multu_7x6_after_reset: done=%b hi=%h lo=%h, required 1/00000000/0000002a", done, hi, lo);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_multu_basic();
    test_mult_signed_back_to_back();
    test_multu_max();
    test_start_while_busy();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
